// File: rtl/dmem_ctrl.sv
// Data-memory access controller: accepts one load/store at a time, checks alignment,
// performs read-modify-write for sub-word stores and sign/zero-extends load results.
module dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        err,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] word_q, word_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        misalign, req_err;
  logic [63:0] merged_word;

  // Bit offset of the addressed lane; low address bits below the access size are ignored.
  function automatic logic [5:0] lane_shift(input logic [2:0] f3, input logic [2:0] a);
    case (f3[1:0])
      2'b00:   return {a, 3'b000};
      2'b01:   return {a[2:1], 4'b0000};
      2'b10:   return {a[2], 5'b00000};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extract(input logic [2:0] f3, input logic [2:0] a,
                                               input logic [63:0] word);
    logic [63:0] s;
    s = word >> lane_shift(f3, a);
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b011:  return s;
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] store_merge(input logic [2:0] f3, input logic [2:0] a,
                                              input logic [63:0] word, input logic [63:0] wd);
    logic [5:0]  sh;
    logic [63:0] m;
    sh = lane_shift(f3, a);
    m  = lane_mask(f3[1:0]);
    return (word & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  always_comb begin
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      2'b11:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    req_err = misalign | (req_funct3 == 3'b111) | (req_write & req_funct3[2]);
  end

  assign merged_word = store_merge(funct3_q, addr_q[2:0], word_q, wdata_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    err_d    = err_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          err_d    = req_err;
          if (req_err)
            state_d = RESP;
          else if (req_write && req_funct3 == 3'b011)
            state_d = WRITE;
          else
            state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d = mem_rdata;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_extract(funct3_q, addr_q[2:0], mem_rdata);
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    err        = (state_q == RESP) && err_q;
    resp_rdata = rdata_q;
    mem_addr   = (state_q == IDLE) ? 64'd0 : {addr_q[63:3], 3'b000};
    mem_wr     = (state_q == WRITE);
    mem_wdata  = 64'd0;
    if (state_q == WRITE)
      mem_wdata = (funct3_q == 3'b011) ? wdata_q : merged_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      err_q    <= err_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a synchronous-read memory model attached.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, err;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic        mem_init;

  logic [63:0] mem     [0:63];
  logic [63:0] ref_mem [0:63];
  logic [63:0] exp_rdata_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          nwr;
    logic [63:0] wword;
  } exp_t;

  exp_t exp_q [$];

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [63:0] init_word(input int i);
    if (i == 32) return 64'h8877665544332211;
    return {32'hA5C30000 + 32'(i), 32'h3C96F00F ^ (32'(i) * 32'h01010101)};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_wr) begin
      mem[mem_addr[8:3]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[8:3]];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte reference model of one access against ref_mem.
  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [63:0] last);
    exp_t        e;
    logic [63:0] word, v;
    int          nb, off;
    logic        mis;
    nb   = 1 << f3[1:0];
    off  = int'(a[2:0]);
    word = ref_mem[a[8:3]];
    mis  = (off % nb) != 0;
    e.err   = mis || (f3 == 3'b111) || (wr && f3[2]);
    e.rdata = last;
    e.nwr   = 0;
    e.wword = 64'd0;
    if (e.err) e.lat = 1;
    else if (!wr) e.lat = 3;
    else if (f3 == 3'b011) e.lat = 2;
    else e.lat = 4;
    if (!e.err && !wr) begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!f3[2] && nb < 8 && v[8*nb-1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
    end
    if (!e.err && wr) begin
      for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      e.wword = word;
      e.nwr   = 1;
    end
    return e;
  endfunction

  task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    exp_t        e, g;
    int          lat, nwr, wr_k;
    logic        got;
    logic [63:0] aligned;
    e = model(wr, f3, a, wd, exp_rdata_last);
    exp_q.push_back(e);
    aligned = {a[63:3], 3'b000};
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_write = ~wr; req_funct3 = f3 ^ 3'b010; req_addr = ~a; req_wdata = ~wd;
    got = 1'b0; lat = 0; nwr = 0; wr_k = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) check_eq({tag, "_addr_busy"}, mem_addr, aligned);
      if (mem_wr) begin
        nwr++;
        wr_k = k;
        check_eq({tag, "_wr_addr"}, mem_addr, aligned);
        check_eq({tag, "_wdata"}, mem_wdata, e.wword);
      end else begin
        check_eq({tag, "_wdata_idle"}, mem_wdata, 64'd0);
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
        check_eq({tag, "_err"}, 64'(err), 64'(e.err));
        check_eq({tag, "_rdata"}, resp_rdata, e.rdata);
        check_eq({tag, "_ready_resp"}, 64'(req_ready), 64'd0);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    g = exp_q.pop_front();
    check_eq({tag, "_resp_seen"}, 64'(got), 64'd1);
    if (got) check_eq({tag, "_latency"}, 64'(lat), 64'(g.lat));
    check_eq({tag, "_nwr"}, 64'(nwr), 64'(g.nwr));
    if (g.nwr == 1) begin
      check_eq({tag, "_wr_cycle"}, 64'(wr_k), 64'(g.lat - 1));
      ref_mem[a[8:3]] = g.wword;
      check_eq({tag, "_mem"}, mem[a[8:3]], g.wword);
    end
    exp_rdata_last = g.rdata;
    @(posedge clk); #1;
    check_eq({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_addr_idle"}, mem_addr, 64'd0);
  endtask

  task automatic reset_mid_sb();
    int nwr, nresp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 64'h111; req_wdata = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_rdwait_addr", mem_addr, 64'h110);
    reset = 1'b1;
    #1;
    check_eq("rst_async_ready", 64'(req_ready), 64'd1);
    check_eq("rst_async_wr", 64'(mem_wr), 64'd0);
    check_eq("rst_async_addr", mem_addr, 64'd0);
    check_eq("rst_async_resp", 64'(resp_valid), 64'd0);
    check_eq("rst_async_rdata", resp_rdata, 64'd0);
    exp_rdata_last = 64'd0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_ready_after", 64'(req_ready), 64'd1);
    nwr = 0; nresp = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mem_wr) nwr++;
      if (resp_valid) nresp++;
    end
    check_eq("rst_no_write", 64'(nwr), 64'd0);
    check_eq("rst_no_resp", 64'(nresp), 64'd0);
    check_eq("rst_mem_unchanged", mem[34], ref_mem[34]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] a, wd;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    exp_rdata_last = 64'd0;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'd0; req_wdata = 64'd0;
    #1;
    check_eq("reset_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("reset_err", 64'(err), 64'd0);
    check_eq("reset_rdata", resp_rdata, 64'd0);
    check_eq("reset_mem_addr", mem_addr, 64'd0);
    check_eq("reset_mem_wr", 64'(mem_wr), 64'd0);
    check_eq("reset_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    check_eq("reset_ready_after", 64'(req_ready), 64'd1);

    run_req("lb", 1'b0, 3'b000, 64'h107, 64'd0);
    check_eq("lb_const", resp_rdata, 64'hFFFFFFFFFFFFFF88);
    run_req("lbu", 1'b0, 3'b100, 64'h107, 64'd0);
    check_eq("lbu_const", resp_rdata, 64'h0000000000000088);
    run_req("lw", 1'b0, 3'b010, 64'h104, 64'd0);
    check_eq("lw_const", resp_rdata, 64'hFFFFFFFF88776655);
    run_req("lwu", 1'b0, 3'b110, 64'h104, 64'd0);
    check_eq("lwu_const", resp_rdata, 64'h0000000088776655);
    run_req("ld", 1'b0, 3'b011, 64'h100, 64'd0);
    check_eq("ld_const", resp_rdata, 64'h8877665544332211);
    run_req("lh", 1'b0, 3'b001, 64'h106, 64'd0);
    check_eq("lh_const", resp_rdata, 64'hFFFFFFFFFFFF8877);
    run_req("lhu", 1'b0, 3'b101, 64'h102, 64'd0);
    check_eq("lhu_const", resp_rdata, 64'h0000000000004433);

    run_req("sb", 1'b1, 3'b000, 64'h102, 64'hFFFF_FFFF_FFFF_FFAB);
    check_eq("sb_mem_const", mem[32], 64'h8877665544AB2211);
    run_req("sd", 1'b1, 3'b011, 64'h108, 64'h0123456789ABCDEF);
    check_eq("sd_mem_const", mem[33], 64'h0123456789ABCDEF);
    run_req("sh", 1'b1, 3'b001, 64'h106, 64'h1234_CAFE);
    run_req("sw", 1'b1, 3'b010, 64'h100, 64'hDEAD_BEEF_0BAD_F00D);
    run_req("ld_after_st", 1'b0, 3'b011, 64'h100, 64'd0);
    check_eq("ld_after_st_const", resp_rdata, 64'hCAFE66550BADF00D);

    run_req("lh_misal", 1'b0, 3'b001, 64'h103, 64'd0);
    check_eq("lh_misal_keep", resp_rdata, 64'hCAFE66550BADF00D);
    run_req("st_f3_100", 1'b1, 3'b100, 64'h100, 64'h77);
    run_req("ld_f3_111", 1'b0, 3'b111, 64'h100, 64'd0);
    run_req("sw_misal", 1'b1, 3'b010, 64'h10A, 64'h55);
    run_req("ld_misal", 1'b0, 3'b011, 64'h104, 64'd0);

    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {32'($urandom), 32'h100 | 32'($urandom_range(0, 255))};
      wd = {32'($urandom), 32'($urandom)};
      run_req("rand", wr, f3, a, wd);
    end

    reset_mid_sb();
    run_req("ld_post_rst", 1'b0, 3'b011, 64'h110, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
